mpu_readback_port: RTL

- MPU-side read path into video RAM; complements the MPU write path that feeds the pending write queue.
- The MPU loads a 17-bit VRAM address through byte registers. The block requests a read slot from the memory manager, latches the returned byte and presents it on a data register.
- Optional auto-increment lets the MPU stream pixels back.
- Sits between the MPU bus pins and the memory manager's read-slot arbiter, alongside the write-path interface.

---
 rtl/mpu_readback_port.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mpu_readback_port.sv
// mpu_readback_port
//   MPU-side read path into video RAM. The MPU loads a VRAM address through
//   byte registers. The block then requests a read slot from the memory
//   manager, latches the returned byte and presents it on the data register.
//   An optional step value auto-increments the address on every data read,
//   so the MPU can stream pixels back.
//
// Ports
//   clock, reset      system clock and synchronous active-high reset
//   chipSelect        asynchronous MPU select; an access commits when it drops
//   writeEnable       1 = write, 0 = read (captured while selected)
//   registerSelect    register index (0..7)
//   registerDataIn    MPU write data
//   registerDataOut   combinational read mux for the raw registerSelect
//   readRequest       high while a VRAM read slot is requested
//   readAddress       address of the outstanding request
//   readGrant         memory manager accepted the request (1-cycle pulse)
//   readDataValid     readData holds the requested byte (1-cycle pulse)
//   readData          VRAM byte
//
// Fetch FSM
//   state     | meaning
//   IDLE      | no fetch outstanding
//   REQUEST   | readRequest held with readAddress until readGrant
//   WAIT_DATA | granted, waiting for readDataValid
module mpu_readback_port #(
  parameter int ADDRESS_WIDTH = 17,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     chipSelect,
  input  logic                     writeEnable,
  input  logic [2:0]               registerSelect,
  input  logic [7:0]               registerDataIn,
  output logic [7:0]               registerDataOut,
  output logic                     readRequest,
  output logic [ADDRESS_WIDTH-1:0] readAddress,
  input  logic                     readGrant,
  input  logic                     readDataValid,
  input  logic [7:0]               readData
);

  localparam int HI_BITS = ADDRESS_WIDTH - 16;

  typedef enum logic [1:0] {IDLE, REQUEST, WAIT_DATA} fetchStateT;

  fetchStateT state, stateNext;

  logic [SYNC_STAGES-1:0]   csSync;
  logic                     csSynced;
  logic                     csPrev;
  logic                     commit;
  logic [2:0]               capSelect;
  logic                     capWrite;
  logic [7:0]               capData;

  logic [ADDRESS_WIDTH-1:0] address, addressNext;
  logic [7:0]               step, stepNext;
  logic [7:0]               dataLatch;
  logic                     dataValid;
  logic                     refetch, refetchNext;
  logic                     trigger;
  logic                     loadAddress;
  logic                     captureData;
  logic                     setValid;

  assign csSynced = csSync[SYNC_STAGES-1];
  // Falling edge of the synchronised select commits the last captured access.
  assign commit   = csPrev & ~csSynced;

  always_comb begin
    addressNext = address;
    stepNext    = step;
    trigger     = 1'b0;
    if (commit) begin
      if (capWrite) begin
        case (capSelect)
          3'd0: addressNext[7:0]  = capData;
          3'd1: addressNext[15:8] = capData;
          3'd2: begin
            addressNext[ADDRESS_WIDTH-1:16] = capData[HI_BITS-1:0];
            trigger = 1'b1;
          end
          3'd5: stepNext = capData;
          default: ;
        endcase
      end else if (capSelect == 3'd3 && step != 8'd0) begin
        // Wraps naturally at the address width.
        addressNext = address + ADDRESS_WIDTH'(step);
        trigger     = 1'b1;
      end
    end
  end

  always_comb begin
    stateNext   = state;
    loadAddress = 1'b0;
    captureData = 1'b0;
    setValid    = 1'b0;
    refetchNext = refetch;
    case (state)
      IDLE: begin
        if (trigger) begin
          stateNext   = REQUEST;
          loadAddress = 1'b1;
        end
      end
      REQUEST: begin
        if (trigger) refetchNext = 1'b1;
        if (readGrant) stateNext = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (readDataValid) begin
          captureData = 1'b1;
          // A trigger landing on the completion edge counts as a refetch so
          // the final byte always belongs to the newest address.
          if (refetch || trigger) begin
            stateNext   = REQUEST;
            loadAddress = 1'b1;
            refetchNext = 1'b0;
          end else begin
            stateNext = IDLE;
            setValid  = 1'b1;
          end
        end else if (trigger) begin
          refetchNext = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      csSync      <= '0;
      csPrev      <= 1'b0;
      capSelect   <= 3'd0;
      capWrite    <= 1'b0;
      capData     <= 8'd0;
      address     <= '0;
      step        <= 8'd1;
      dataLatch   <= 8'd0;
      dataValid   <= 1'b0;
      refetch     <= 1'b0;
      readAddress <= '0;
    end else begin
      csSync <= (csSync << 1) | SYNC_STAGES'(chipSelect);
      csPrev <= csSynced;
      if (csSynced) begin
        capSelect <= registerSelect;
        capWrite  <= writeEnable;
        capData   <= registerDataIn;
      end
      address <= addressNext;
      step    <= stepNext;
      refetch <= refetchNext;
      if (captureData) dataLatch <= readData;
      if (trigger) begin
        dataValid <= 1'b0;
      end else if (setValid) begin
        dataValid <= 1'b1;
      end
      if (loadAddress) readAddress <= addressNext;
    end
  end

  assign readRequest = (state == REQUEST);

  always_comb begin
    registerDataOut = 8'd0;
    case (registerSelect)
      3'd0: registerDataOut = address[7:0];
      3'd1: registerDataOut = address[15:8];
      3'd2: registerDataOut[HI_BITS-1:0] = address[ADDRESS_WIDTH-1:16];
      3'd3: registerDataOut = dataLatch;
      3'd4: registerDataOut = {6'd0, dataValid, state != IDLE};
      3'd5: registerDataOut = step;
      default: registerDataOut = 8'd0;
    endcase
  end

endmodule
